// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array result collector.
package systolic_pkg;

  localparam int DEFAULT_DIN_WIDTH = 8;
  localparam int DEFAULT_N         = 4;
  localparam int RESULT_W          = 2 * DEFAULT_DIN_WIDTH;

  typedef logic [RESULT_W-1:0]   result_t;
  typedef result_t [DEFAULT_N-1:0] row_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } asm_state_t;

  // Index/pointer width that stays legal for a one-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Result beats in from the array, assembled rows and status out.
interface systolic_result_collector_if
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = DEFAULT_DIN_WIDTH,
  parameter int N         = DEFAULT_N
) ();

  localparam int RW = 2 * DIN_WIDTH;
  localparam int IW = idx_width(N);

  logic                out_valid;
  logic [RW-1:0]       c_dout;
  logic [IW-1:0]       c_dout_idx;
  logic                row_valid;
  logic                row_ready;
  logic [N*RW-1:0]     row_data;
  logic                err_seq;
  logic                err_ovf;
  logic                busy;

  modport master (
    output out_valid, c_dout, c_dout_idx, row_ready,
    input  row_valid, row_data, err_seq, err_ovf, busy
  );

  modport slave (
    input  out_valid, c_dout, c_dout_idx, row_ready,
    output row_valid, row_data, err_seq, err_ovf, busy
  );

endinterface

// File: rtl/systolic_result_collector_row_fifo.sv
// Show-ahead FIFO of whole rows; a push while full is taken only alongside a pop.
module row_fifo
  import systolic_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = row_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data,
  output logic   full,
  output logic   empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign out_valid = !empty;
  assign out_data  = mem_reg[rd_ptr_reg];
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);

  // Entries are cleared on reset so the output reads zero until the first row.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (push && wr_ptr_reg == PW'(gi)) begin
        mem_reg[gi] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Assembles in-order column results into rows and buffers them for a valid/ready sink.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = DEFAULT_DIN_WIDTH,
  parameter int N         = DEFAULT_N,
  parameter int DEPTH     = 2
) (
  input logic                        clk,
  input logic                        rst,
  systolic_result_collector_if.slave bus
);

  localparam int RW = 2 * DIN_WIDTH;
  localparam int IW = idx_width(N);

  typedef logic [RW-1:0]  word_t;
  typedef word_t [N-1:0]  line_t;

  asm_state_t      state_reg;
  logic [IW-1:0]   exp_idx_reg;
  logic            err_seq_reg;
  logic            err_ovf_reg;

  logic            in_order;
  logic            beat_ok;
  logic            restart;
  logic            store;
  logic            complete;
  logic            pop;
  logic            drop;
  line_t           push_row;
  line_t           fifo_data;
  logic            fifo_valid;
  logic            fifo_full;
  logic            fifo_empty;

  assign in_order = (state_reg == IDLE) ? (bus.c_dout_idx == '0)
                                        : (bus.c_dout_idx == exp_idx_reg);
  assign beat_ok  = bus.out_valid && in_order;
  // An out-of-order idx 0 is the start of a fresh row, not just an error.
  assign restart  = bus.out_valid && !in_order && (bus.c_dout_idx == '0);
  assign store    = beat_ok || restart;
  assign complete = beat_ok && (bus.c_dout_idx == IW'(N - 1));
  assign pop      = fifo_valid && bus.row_ready;
  assign drop     = complete && fifo_full && !pop;

  // The final result goes straight into the pushed row, so no slot holds it.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    if (gi == N - 1) begin : g_last
      assign push_row[gi] = bus.c_dout;
    end else begin : g_held
      word_t slot_reg;
      always_ff @(posedge clk) begin
        if (store && bus.c_dout_idx == IW'(gi)) begin
          slot_reg <= bus.c_dout;
        end
      end
      assign push_row[gi] = slot_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      exp_idx_reg <= '0;
      err_seq_reg <= 1'b0;
      err_ovf_reg <= 1'b0;
    end else begin
      if (bus.out_valid && !in_order) err_seq_reg <= 1'b1;
      if (drop)                       err_ovf_reg <= 1'b1;
      if (bus.out_valid) begin
        if (complete) begin
          state_reg   <= IDLE;
          exp_idx_reg <= '0;
        end else if (store) begin
          state_reg   <= FILL;
          exp_idx_reg <= restart ? IW'(1) : exp_idx_reg + IW'(1);
        end else begin
          state_reg   <= IDLE;
          exp_idx_reg <= '0;
        end
      end
    end
  end

  row_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (line_t)
  ) u_row_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (complete),
    .in_data   (push_row),
    .out_valid (fifo_valid),
    .out_ready (bus.row_ready),
    .out_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.row_valid = fifo_valid;
  assign bus.row_data  = fifo_data;
  assign bus.err_seq   = err_seq_reg;
  assign bus.err_ovf   = err_ovf_reg;
  assign bus.busy      = (state_reg == FILL) || !fifo_empty;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed and randomized checks of the row collector against a queue-based model.
module tb_systolic_result_collector;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int RW    = 2 * DW;

  typedef logic [N*RW-1:0] rowbits_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_result_collector_if #(.DIN_WIDTH(DW), .N(N)) bus ();

  systolic_result_collector #(.DIN_WIDTH(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference: beats collected so far, rows waiting downstream, sticky flags.
  logic [RW-1:0] partial[$];
  rowbits_t      fq[$];
  bit            m_err_seq;
  bit            m_err_ovf;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("row_valid", 128'(bus.row_valid), 128'(fq.size() != 0));
    if (fq.size() != 0) check("row_data", 128'(bus.row_data), 128'(fq[0]));
    check("err_seq", 128'(bus.err_seq), 128'(m_err_seq));
    check("err_ovf", 128'(bus.err_ovf), 128'(m_err_ovf));
    check("busy", 128'(bus.busy), 128'((partial.size() != 0) || (fq.size() != 0)));
  endtask

  task automatic step(input bit v, input int idx, input logic [RW-1:0] data, input bit ready);
    bit       pop;
    bit       done;
    rowbits_t row;
    bus.out_valid  = v;
    bus.c_dout_idx = idx[1:0];
    bus.c_dout     = data;
    bus.row_ready  = ready;
    done = 1'b0;
    row  = '0;
    if (rst) begin
      partial.delete();
      fq.delete();
      m_err_seq = 1'b0;
      m_err_ovf = 1'b0;
    end else begin
      pop = (fq.size() != 0) && ready;
      if (v) begin
        if (idx == partial.size()) begin
          partial.push_back(data);
          if (partial.size() == N) begin
            for (int k = 0; k < N; k++) row[k*RW +: RW] = partial[k];
            partial.delete();
            done = 1'b1;
          end
        end else begin
          m_err_seq = 1'b1;
          partial.delete();
          if (idx == 0) partial.push_back(data);
        end
      end
      if (pop) begin
        $display("row out %h", fq[0]);
        void'(fq.pop_front());
      end
      if (done) begin
        if (fq.size() < DEPTH) fq.push_back(row);
        else m_err_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic beat(input int idx, input logic [RW-1:0] data, input bit ready);
    step(1'b1, idx, data, ready);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, N-1), RW'($urandom), ready);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, $urandom_range(0, N-1), RW'($urandom), 1'b1);
    step(1'b1, 0, RW'($urandom), 1'b1);
    rst = 1'b0;
    check("rst_row_data", 128'(bus.row_data), 128'(0));
    check("rst_row_valid", 128'(bus.row_valid), 128'(0));
  endtask

  task automatic full_row(input bit ready);
    for (int k = 0; k < N; k++) beat(k, RW'($urandom), ready);
  endtask

  initial begin
    bus.out_valid  = 1'b0;
    bus.c_dout     = '0;
    bus.c_dout_idx = '0;
    bus.row_ready  = 1'b0;
    m_err_seq = 1'b0;
    m_err_ovf = 1'b0;

    do_reset();

    // Known row, gap-free, sink always ready
    for (int k = 0; k < N; k++) beat(k, RW'((k + 1) * 16'h0011), 1'b1);
    check("basic_row", 128'(bus.row_data), 128'(64'h0044_0033_0022_0011));
    check("basic_valid", 128'(bus.row_valid), 128'(1));
    idle(2, 1'b1);

    // Three rows into a blocked sink: two kept, one dropped
    for (int r = 0; r < 3; r++) full_row(1'b0);
    check("ovf_set", 128'(bus.err_ovf), 128'(1));
    idle(4, 1'b1);
    do_reset();

    // Sequence error then a clean row
    beat(0, 16'h1000, 1'b1);
    beat(1, 16'h1001, 1'b1);
    beat(3, 16'h1003, 1'b1);
    check("seq_set", 128'(bus.err_seq), 128'(1));
    full_row(1'b1);
    idle(2, 1'b1);
    do_reset();

    // FIFO full, pop coincides with completion of a third row
    full_row(1'b0);
    full_row(1'b0);
    for (int k = 0; k < N - 1; k++) beat(k, RW'($urandom), 1'b0);
    beat(N - 1, RW'($urandom), 1'b1);
    check("ovf_clear", 128'(bus.err_ovf), 128'(0));
    idle(4, 1'b1);

    // Reset in the middle of a row, then a good row
    full_row(1'b0);
    beat(0, RW'($urandom), 1'b0);
    beat(1, RW'($urandom), 1'b0);
    do_reset();
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_err", 128'({bus.err_seq, bus.err_ovf}), 128'(0));
    full_row(1'b1);
    idle(2, 1'b1);

    // Random idle gaps between beats
    for (int k = 0; k < N; k++) begin
      idle($urandom_range(0, 5), 1'b0);
      beat(k, RW'($urandom), 1'b0);
    end
    idle(2, 1'b1);

    // Randomized traffic with occasional bad indices and a stalling sink
    for (int i = 0; i < 600; i++) begin
      int nidx;
      nidx = (partial.size() < N) ? partial.size() : 0;
      if ($urandom_range(0, 9) == 0) nidx = $urandom_range(0, N - 1);
      if (i == 300) do_reset();
      step($urandom_range(0, 2) != 0, nidx, RW'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(6, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_result_collector.md
SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

Interface
REQ-001 The block SHALL have parameter DIN_WIDTH, default 8, meaning operand width; results are 2*DIN_WIDTH bits wide.
REQ-002 The block SHALL have parameter N, default 4, meaning array dimension and the number of results per row.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of row entries in the output FIFO.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port out_valid, input, 1 bit: the array result beat is valid.
REQ-007 The block SHALL have port c_dout, input, 2*DIN_WIDTH bits: the array result value.
REQ-008 The block SHALL have port c_dout_idx, input, $clog2(N) bits: the column index of c_dout.
REQ-009 The block SHALL have port row_valid, output, 1 bit: row_data holds a complete row.
REQ-010 The block SHALL have port row_ready, input, 1 bit: the downstream accepts the row.
REQ-011 The block SHALL have port row_data, output, N*2*DIN_WIDTH bits: element k at [k*2*DIN_WIDTH +: 2*DIN_WIDTH].
REQ-012 The block SHALL have port err_seq, output, 1 bit: sticky flag for an index-sequence violation.
REQ-013 The block SHALL have port err_ovf, output, 1 bit: sticky flag for a row dropped on a full FIFO.
REQ-014 The block SHALL have port busy, output, 1 bit: the assembler is in FILL or the FIFO is non-empty.

Function
REQ-015 The assembler FSM SHALL have states IDLE and FILL, plus a counter exp_idx.
REQ-016 In IDLE, a beat with idx==0 SHALL be stored in slot 0, set exp_idx=1 and go to FILL; for N==1 it completes the row immediately.
REQ-017 In IDLE, a beat with idx!=0 SHALL be discarded, set err_seq and stay in IDLE.
REQ-018 In FILL, a beat with idx==exp_idx SHALL be stored and increment exp_idx.
REQ-019 A beat with idx==N-1 in order SHALL complete the row, push it to the FIFO and return to IDLE.
REQ-020 In FILL, an out-of-order beat SHALL set err_seq and discard the partial row.
REQ-021 After an out-of-order beat, the FSM SHALL restart in FILL with exp_idx=1 if the beat idx==0, else go to IDLE.
REQ-022 Cycles without out_valid SHALL NOT change assembler state; gaps between beats are legal.
REQ-023 A completed row SHALL appear on row_valid/row_data the cycle after its final beat when the FIFO was empty, giving latency 1.
REQ-024 Rows SHALL leave in completion order; a transfer occurs when row_valid and row_ready are both high.
REQ-025 row_data and row_valid SHALL stay stable while row_valid is high and row_ready is low.
REQ-026 A push onto a full FIFO SHALL succeed if a pop occurs in the same cycle; otherwise the row is dropped and err_ovf is set.
REQ-027 Simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-028 Results SHALL be stored unmodified, with no arithmetic and no width change.
REQ-029 err_seq and err_ovf SHALL be cleared only by rst.

Reset
REQ-030 On rst high at a clock edge, the FSM SHALL go to IDLE with exp_idx=0, the FIFO empty, and row_valid=0, err_seq=0, err_ovf=0, busy=0.
REQ-031 row_data SHALL be 0 after reset.
REQ-032 A reset asserted mid-row or with the FIFO occupied SHALL discard all partial and buffered rows, and inputs during reset SHALL be ignored.

Structure
REQ-033 Package systolic_pkg SHALL hold the result type (2*DIN_WIDTH logic), the row type (N-element array of results), the FSM state enum and the default constants DIN_WIDTH=8 and N=4.
REQ-034 The output buffer SHALL be one sub-module, row_fifo: DEPTH entries of row type, valid/ready, synchronous active-high reset, with full/empty outputs.

Verification
REQ-035 With N=4 and row_ready=1, beats idx 0..3 with values 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles SHALL give row_valid one cycle after the last beat and row_data=0x0044_0033_0022_0011.
REQ-036 With row_ready=0, three full rows back to back SHALL leave two rows buffered, drop the third, set err_ovf=1, and with ready raised deliver the first two in order.
REQ-037 Beats idx 0,1,3 followed by 0,1,2,3 SHALL set err_seq=1 at the idx-3 beat and deliver exactly one row, the second.
REQ-038 With the FIFO full and row_ready=1 in the cycle a new row completes, the row SHALL be accepted, err_ovf SHALL stay 0, and the order SHALL be preserved.
REQ-039 rst asserted after beats idx 0,1 SHALL give all outputs 0 the next cycle, and a following full row SHALL be delivered correctly.
REQ-040 Beats idx 0..3 with random idle gaps of 0-5 cycles between them SHALL produce a row identical to the gap-free case.
